mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a single-port RAM: checks alignment,
// builds lane strobes, waits for ram_ack with a timeout and extends load data.
module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_write,
   input  logic [1:0]          req_size,
   input  logic                req_sign_ext,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                req_ready,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                addr_read_error,
   output logic                addr_write_error,
   output logic                bus_error,
   output logic                stall,
   output logic                ram_en,
   output logic [DATA_W/8-1:0] ram_write_en,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_write_data,
   input  logic [DATA_W-1:0]   ram_read_data,
   input  logic                ram_ack
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   logic              write_r;
   logic [1:0]        size_r;
   logic              sext_r;
   logic [OFF_W-1:0]  off_r;
   logic [15:0]       wait_cnt_r;

   logic [OFF_W-1:0]  off_s;
   logic              illegal_s;
   logic [LANES-1:0]  base_s;
   logic [LANES-1:0]  lanes_s;
   logic [DATA_W-1:0] wdata_shift_s;
   logic [DATA_W-1:0] rd_shift_s;
   logic [DATA_W-1:0] keep_s;
   logic              sign_s;
   logic [DATA_W-1:0] rdata_s;
   logic              timeout_s;

   assign off_s         = req_addr[OFF_W-1:0];
   assign wdata_shift_s = req_wdata << {off_s, 3'b000};
   assign lanes_s       = base_s << off_s;
   assign rd_shift_s    = ram_read_data >> {off_r, 3'b000};
   assign rdata_s       = (rd_shift_s & keep_s) | ((sext_r && sign_s) ? ~keep_s : '0);
   // This is the last waiting cycle: the counter would reach TIMEOUT on this edge.
   assign timeout_s     = (wait_cnt_r == 16'(TIMEOUT - 1));
   assign stall         = ((state_r != IDLE) && !resp_valid) || ((state_r == IDLE) && req_valid);

   // Request legality and byte-lane pattern for the incoming request.
   always_comb begin
      illegal_s = 1'b0;
      base_s    = '0;
      case (req_size)
         2'b00: begin
            illegal_s = 1'b0;
            base_s    = LANES'(8'h01);
         end
         2'b01: begin
            illegal_s = req_addr[0];
            base_s    = LANES'(8'h03);
         end
         2'b10: begin
            illegal_s = (req_addr[1:0] != 2'b00);
            base_s    = LANES'(8'h0F);
         end
         default: begin
            illegal_s = (DATA_W != 64) || (req_addr[2:0] != 3'b000);
            base_s    = LANES'(8'hFF);
         end
      endcase
   end

   // Width mask and sign bit for the latched load size.
   always_comb begin
      keep_s = '1;
      sign_s = 1'b0;
      case (size_r)
         2'b00: begin
            keep_s = DATA_W'(8'hFF);
            sign_s = rd_shift_s[7];
         end
         2'b01: begin
            keep_s = DATA_W'(16'hFFFF);
            sign_s = rd_shift_s[15];
         end
         2'b10: begin
            keep_s = DATA_W'(32'hFFFF_FFFF);
            sign_s = rd_shift_s[31];
         end
         default: begin
            keep_s = '1;
            sign_s = 1'b0;
         end
      endcase
   end

   // Access FSM with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         write_r          <= 1'b0;
         size_r           <= 2'b00;
         sext_r           <= 1'b0;
         off_r            <= '0;
         wait_cnt_r       <= 16'd0;
         req_ready        <= 1'b1;
         resp_valid       <= 1'b0;
         resp_rdata       <= '0;
         addr_read_error  <= 1'b0;
         addr_write_error <= 1'b0;
         bus_error        <= 1'b0;
         ram_en           <= 1'b0;
         ram_write_en     <= '0;
         ram_addr         <= '0;
         ram_write_data   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               resp_valid       <= 1'b0;
               addr_read_error  <= 1'b0;
               addr_write_error <= 1'b0;
               bus_error        <= 1'b0;
               resp_rdata       <= '0;
               if (req_valid) begin
                  write_r   <= req_write;
                  size_r    <= req_size;
                  sext_r    <= req_sign_ext;
                  off_r     <= off_s;
                  req_ready <= 1'b0;
                  if (illegal_s) begin
                     state_r          <= RESP;
                     resp_valid       <= 1'b1;
                     addr_read_error  <= !req_write;
                     addr_write_error <= req_write;
                  end else begin
                     state_r        <= ACCESS;
                     wait_cnt_r     <= 16'd0;
                     ram_en         <= 1'b1;
                     ram_addr       <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     ram_write_en   <= req_write ? lanes_s : '0;
                     ram_write_data <= req_write ? wdata_shift_s : '0;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ACCESS: begin
               if (ram_ack || timeout_s) begin
                  state_r        <= RESP;
                  resp_valid     <= 1'b1;
                  bus_error      <= !ram_ack;
                  resp_rdata     <= (ram_ack && !write_r) ? rdata_s : '0;
                  ram_en         <= 1'b0;
                  ram_write_en   <= '0;
                  ram_addr       <= '0;
                  ram_write_data <= '0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end
            RESP: begin
               state_r          <= IDLE;
               req_ready        <= 1'b1;
               resp_valid       <= 1'b0;
               resp_rdata       <= '0;
               addr_read_error  <= 1'b0;
               addr_write_error <= 1'b0;
               bus_error        <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               req_ready <= 1'b1;
               ram_en    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Runs a 32-bit and a 64-bit mem_access_unit in lockstep on shared stimulus
// and checks every cycle of each transaction against a transaction-level model.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write, req_sign_ext, ram_ack;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, ram_rd;

   logic        a_ready, a_rv, a_rerr, a_werr, a_berr, a_stall, a_en;
   logic [31:0] a_rdata, a_addr, a_wd;
   logic [3:0]  a_we;
   logic        b_ready, b_rv, b_rerr, b_werr, b_berr, b_stall, b_en;
   logic [63:0] b_rdata, b_wd;
   logic [31:0] b_addr;
   logic [7:0]  b_we;

   int n_cmp = 0;
   int n_bad = 0;

   logic        t_write, t_sext;
   logic [1:0]  t_size;
   logic [31:0] t_addr;
   logic [63:0] t_wdata, t_rd;
   int          t_delay;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
      .req_wdata(req_wdata[31:0]), .req_ready(a_ready), .resp_valid(a_rv),
      .resp_rdata(a_rdata), .addr_read_error(a_rerr), .addr_write_error(a_werr),
      .bus_error(a_berr), .stall(a_stall), .ram_en(a_en), .ram_write_en(a_we),
      .ram_addr(a_addr), .ram_write_data(a_wd), .ram_read_data(ram_rd[31:0]),
      .ram_ack(ram_ack));

   mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(b_ready), .resp_valid(b_rv),
      .resp_rdata(b_rdata), .addr_read_error(b_rerr), .addr_write_error(b_werr),
      .bus_error(b_berr), .stall(b_stall), .ram_en(b_en), .ram_write_en(b_we),
      .ram_addr(b_addr), .ram_write_data(b_wd), .ram_read_data(ram_rd),
      .ram_ack(ram_ack));

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input int dw, input logic [1:0] size, input logic [31:0] addr);
      int bytes = 1 << size;
      if (size == 2'd3 && dw == 32) return 1'b0;
      return (addr % bytes) == 0;
   endfunction

   function automatic logic [63:0] low_mask(input int bytes);
      if (bytes >= 8) return {64{1'b1}};
      return (64'd1 << (8 * bytes)) - 64'd1;
   endfunction

   // Expected per-cycle behaviour of one DUT for the current transaction.
   task automatic check_side(input int dw, input int c);
      bit lg = legal(dw, t_size, t_addr);
      bit to = (t_delay >= TO);
      int n = to ? TO : t_delay + 1;
      int rc = lg ? n + 1 : 1;
      int bytes = 1 << t_size;
      int off = int'(t_addr % (dw / 8));
      logic [63:0] dmask = low_mask(dw / 8);
      logic [63:0] e_rd, v;
      logic [6:0] e_ctrl, o_ctrl;
      string tg = $sformatf("dw%0d c%0d sz%0d a%h w%0d", dw, c, t_size, t_addr, t_write);
      v = ((t_rd & dmask) >> (8 * off)) & low_mask(bytes);
      if (t_sext && v[8 * bytes - 1]) v = v | ~low_mask(bytes);
      e_rd = (t_write || !lg || to) ? 64'd0 : (v & dmask);
      e_ctrl = {lg && c >= 1 && c <= n, c == rc, c == rc && !lg && !t_write,
                c == rc && !lg && t_write, c == rc && lg && to,
                c == 0 || c < rc, c == 0 || c > rc};
      if (dw == 32) o_ctrl = {a_en, a_rv, a_rerr, a_werr, a_berr, a_stall, a_ready};
      else          o_ctrl = {b_en, b_rv, b_rerr, b_werr, b_berr, b_stall, b_ready};
      check_eq({tg, " ctrl"}, 64'(o_ctrl), 64'(e_ctrl));
      if (e_ctrl[6]) begin
         check_eq({tg, " ram_addr"}, (dw == 32) ? 64'(a_addr) : 64'(b_addr),
                  64'(t_addr - 32'(off)));
         check_eq({tg, " ram_we"}, (dw == 32) ? 64'(a_we) : 64'(b_we),
                  t_write ? 64'(((1 << bytes) - 1) << off) : 64'd0);
         if (t_write)
            check_eq({tg, " ram_wd"}, (dw == 32) ? 64'(a_wd) : b_wd,
                     ((t_wdata & dmask) << (8 * off)) & dmask);
      end
      if (e_ctrl[5])
         check_eq({tg, " rdata"}, (dw == 32) ? 64'(a_rdata) : b_rdata, e_rd);
   endtask

   task automatic run_txn(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] ad, input logic [63:0] wd,
                          input logic [63:0] rd, input int dly);
      t_write = w; t_size = sz; t_sext = sx; t_addr = ad;
      t_wdata = wd; t_rd = rd; t_delay = dly;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_sign_ext = sx;
      req_addr = ad; req_wdata = wd; ram_rd = rd; ram_ack = 1'b0;
      #1;
      check_side(32, 0);
      check_side(64, 0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check_side(32, c);
         check_side(64, c);
         req_valid    = 1'b0;
         req_write    = 1'($urandom);
         req_size     = 2'($urandom);
         req_sign_ext = 1'($urandom);
         req_addr     = $urandom;
         req_wdata    = {$urandom, $urandom};
         ram_ack      = (c == t_delay + 1);
      end
      ram_ack = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " ctrl32"}, 64'({a_en, a_rv, a_rerr, a_werr, a_berr, a_stall, a_ready}), 64'd1);
      check_eq({tag, " ctrl64"}, 64'({b_en, b_rv, b_rerr, b_werr, b_berr, b_stall, b_ready}), 64'd1);
   endtask

   initial begin
      logic [31:0] ad;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_sign_ext = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
      ram_rd = 64'd0; ram_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      check_eq("reset rdata", {a_rdata, 32'd0} | b_rdata, 64'd0);
      check_eq("reset bus", {a_we, b_we, a_addr | b_addr}, 64'd0);
      check_eq("reset wd", {a_wd, 32'd0} | b_wd, 64'd0);
      rst = 1'b0;

      run_txn(1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 64'h0000_0000_80AA_BBCC, 0);
      run_txn(1'b1, 2'd1, 1'b0, 32'h202, 64'h1234, 64'd0, 0);
      run_txn(1'b0, 2'd2, 1'b0, 32'h101, 64'd0, 64'hDEAD_BEEF, 0);
      run_txn(1'b0, 2'd2, 1'b1, 32'h100, 64'd0, 64'hFFFF_FFFF, 9);
      run_txn(1'b0, 2'd1, 1'b1, 32'h106, 64'd0, 64'h8001_2345_6789_ABCD, TO - 1);
      run_txn(1'b1, 2'd3, 1'b0, 32'h18, 64'h0123_4567_89AB_CDEF, 64'd0, 1);
      run_txn(1'b0, 2'd3, 1'b1, 32'h20, 64'd0, 64'h8765_4321_0FED_CBA9, 2);

      for (int i = 0; i < 150; i++) begin
         ad = $urandom;
         if ($urandom_range(0, 1) == 0) ad[2:0] = 3'd0;
         run_txn(1'($urandom), 2'($urandom), 1'($urandom), ad,
                 {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 5)));
      end

      // Reset in the second ACCESS cycle abandons the access silently.
      t_write = 1'b0; t_size = 2'd2; t_sext = 1'b0; t_addr = 32'h300;
      t_wdata = 64'd0; t_rd = 64'd0; t_delay = 99;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         check_side(32, c);
         check_side(64, c);
         req_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle("rst_access");
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_idle($sformatf("post_rst%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
